// File: rtl/interval_scan_scheduler_pkg.sv
// Shared types and constants for the interval scan scheduler.
// Channel index width, FSM state encoding, failure-word flag bit.
package interval_scan_pkg;

  localparam int CH_W = 5;
  localparam int FAILED_VALID_BIT = 63;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CLEAR,
    DWELL,
    DRAIN,
    REPORT
  } state_t;

endpackage

// File: rtl/interval_scan_scheduler_rr_next_channel.sv
// Combinational round-robin finder: next enabled channel after cur.
// Ports: mask (enables), cur, origin -> found, next_idx, wrapped.
module rr_next_channel
  import interval_scan_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]    mask,
  input  logic [CH_W-1:0] cur,
  input  logic [CH_W-1:0] origin,
  output logic            found,
  output logic [CH_W-1:0] next_idx,
  output logic            wrapped
);

  logic [31:0] m32;

  assign m32 = 32'(mask);

  // wrapped: the candidate lies beyond origin, walking forward from cur
  always_comb begin
    int idx;
    int lim;
    int steps;
    found    = 1'b0;
    next_idx = '0;
    steps    = 0;
    lim      = (int'(origin) - int'(cur) + N) % N;
    for (int s = 1; s <= N; s++) begin
      idx = int'(cur) + s;
      if (idx >= N) idx = idx - N;
      if (!found && m32[CH_W'(idx)]) begin
        found    = 1'b1;
        next_idx = CH_W'(idx);
        steps    = s;
      end
    end
    wrapped = found && (steps > lim);
  end

endmodule

// File: rtl/interval_scan_scheduler.sv
// Steps the tag interval checker over enabled channels: clear, dwell,
// drain, then reports each channel's failure word over valid/ready.
// Ports: start/abort/continuous + mask/dwell config; chk_* to checker;
// res_* result stream; busy, done pulse, saturating fail_count.
module interval_scan_scheduler
  import interval_scan_pkg::*;
#(
  parameter int NUM_CHANNELS = 32,
  parameter int CLEAR_CYCLES = 4,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    continuous,
  input  logic [NUM_CHANNELS-1:0] channel_mask,
  input  logic [31:0]             dwell_cycles,
  output logic                    chk_hold,
  output logic [CH_W-1:0]         chk_channel,
  input  logic [63:0]             chk_failed,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [CH_W-1:0]         res_channel,
  output logic [63:0]             res_failed,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             fail_count
);

  localparam logic [CH_W-1:0] ORIGIN =
    CH_W'(NUM_CHANNELS - 1);
  localparam logic [31:0] CLEAR_LAST =
    32'(CLEAR_CYCLES - 1);
  localparam logic [31:0] DRAIN_LAST =
    32'(DRAIN_CYCLES - 1);

  state_t                  state;
  logic [NUM_CHANNELS-1:0] mask_q;
  logic [31:0]             dwell_q;
  logic [31:0]             dwell_last;
  logic [31:0]             cnt;
  logic                    cont_q;
  logic                    fresh;
  logic [CH_W-1:0]         cur;
  logic                    found;
  logic                    wrapped;
  logic [CH_W-1:0]         next_idx;

  // dwell of 0 behaves as 1 cycle
  assign dwell_last = (dwell_q == 32'd0) ?
                      32'd0 : dwell_q - 32'd1;
  assign busy     = (state != IDLE);
  assign chk_hold = !(state == DWELL || state == DRAIN);

  // cur = ORIGIN with fresh set stands for "before channel 0"
  rr_next_channel #(
    .N(NUM_CHANNELS)
  ) u_rr (
    .mask    (mask_q),
    .cur     (cur),
    .origin  (ORIGIN),
    .found   (found),
    .next_idx(next_idx),
    .wrapped (wrapped)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mask_q      <= '0;
      dwell_q     <= '0;
      cnt         <= '0;
      cont_q      <= 1'b0;
      fresh       <= 1'b0;
      cur         <= '0;
      chk_channel <= '0;
      res_valid   <= 1'b0;
      res_channel <= '0;
      res_failed  <= '0;
      done        <= 1'b0;
      fail_count  <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        res_valid <= 1'b0;
        cnt       <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !abort) begin
              mask_q     <= channel_mask;
              dwell_q    <= dwell_cycles;
              cont_q     <= continuous;
              fail_count <= '0;
              cur        <= ORIGIN;
              fresh      <= 1'b1;
              state      <= SELECT;
            end
          end
          SELECT: begin
            fresh <= 1'b0;
            cnt   <= '0;
            if (!found) begin
              done  <= !cont_q;
              state <= IDLE;
            end else if (wrapped && !fresh) begin
              // pass complete; a new pass starts at next_idx
              if (cont_q) begin
                fail_count  <= '0;
                cur         <= next_idx;
                chk_channel <= next_idx;
                state       <= CLEAR;
              end else begin
                done  <= 1'b1;
                state <= IDLE;
              end
            end else begin
              cur         <= next_idx;
              chk_channel <= next_idx;
              state       <= CLEAR;
            end
          end
          CLEAR: begin
            if (cnt == CLEAR_LAST) begin
              cnt   <= '0;
              state <= DWELL;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          DWELL: begin
            if (cnt == dwell_last) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          DRAIN: begin
            if (cnt == DRAIN_LAST) begin
              cnt         <= '0;
              res_failed  <= chk_failed;
              res_channel <= cur;
              res_valid   <= 1'b1;
              if (chk_failed[FAILED_VALID_BIT] &&
                  fail_count != 16'hFFFF)
                fail_count <= fail_count + 16'd1;
              state <= REPORT;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          REPORT: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              state     <= SELECT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_interval_scan_scheduler.sv
// Scoreboard bench for interval_scan_scheduler.
// Directed scans; a negedge monitor pops expected results.
module tb_interval_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        continuous;
  logic [31:0] channel_mask;
  logic [31:0] dwell_cycles;
  logic        chk_hold;
  logic [4:0]  chk_channel;
  logic [63:0] chk_failed;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_channel;
  logic [63:0] res_failed;
  logic        busy;
  logic        done;
  logic [15:0] fail_count;

  logic [31:0] fail_mask;
  logic [68:0] exp_q[$];
  logic [68:0] mon_e;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  interval_scan_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .continuous  (continuous),
    .channel_mask(channel_mask),
    .dwell_cycles(dwell_cycles),
    .chk_hold    (chk_hold),
    .chk_channel (chk_channel),
    .chk_failed  (chk_failed),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_channel (res_channel),
    .res_failed  (res_failed),
    .busy        (busy),
    .done        (done),
    .fail_count  (fail_count)
  );

  function automatic logic [63:0] word(
    input logic [4:0] ch,
    input logic       f
  );
    return {f, 39'd0, 16'hC0DE, 3'd0, ch};
  endfunction

  // checker model: failure word depends on selected channel
  always_comb
    chk_failed = word(chk_channel, fail_mask[chk_channel]);

  task automatic check(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic expect_res(input logic [4:0] ch);
    exp_q.push_back({ch, word(ch, fail_mask[ch])});
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got ch %0d, expected none",
                 res_channel);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_channel", 64'(res_channel),
              64'(mon_e[68:64]));
        check("res_failed", res_failed, mon_e[63:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(done), 64'd1);
    tick();
    check({name, "_pulse_end"}, 64'(done), 64'd0);
  endtask

  task automatic wait_valid(output int n, input int budget);
    n = 0;
    while (!res_valid && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int  n;
    int  xf;
    logic stable;

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    continuous = 1'b0;
    channel_mask = '0;
    dwell_cycles = '0;
    res_ready = 1'b1;
    fail_mask = '0;
    #12;
    check("rst_hold", 64'(chk_hold), 64'd1);
    check("rst_ch", 64'(chk_channel), 64'd0);
    check("rst_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_fc", 64'(fail_count), 64'd0);
    check("rst_rfail", res_failed, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // two channels, ch2 fails
    channel_mask = 32'h5;
    dwell_cycles = 32'd100;
    fail_mask = 32'h4;
    expect_res(5'd0);
    expect_res(5'd2);
    pulse_start();
    wait_valid(n, 500);
    check("t1_latency", 64'(n), 64'd113);
    wait_done(400, "t1_done");
    check("t1_fc", 64'(fail_count), 64'd1);
    check("t1_q", 64'(exp_q.size()), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);

    // empty mask
    channel_mask = 32'h0;
    pulse_start();
    check("t2_busy1", 64'(busy), 64'd1);
    check("t2_done1", 64'(done), 64'd0);
    tick();
    check("t2_done2", 64'(done), 64'd1);
    check("t2_busy2", 64'(busy), 64'd0);
    check("t2_valid", 64'(res_valid), 64'd0);
    tick();
    check("t2_done3", 64'(done), 64'd0);

    // back-pressure on first result
    channel_mask = 32'h8000_0001;
    dwell_cycles = 32'd10;
    fail_mask = 32'h8000_0000;
    res_ready = 1'b0;
    expect_res(5'd0);
    expect_res(5'd31);
    pulse_start();
    wait_valid(n, 100);
    check("t3_valid_seen", 64'(res_valid), 64'd1);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (res_valid !== 1'b1 || res_channel !== 5'd0 ||
          chk_hold !== 1'b1 || chk_channel !== 5'd0 ||
          res_failed !== word(5'd0, 1'b0))
        stable = 1'b0;
      tick();
    end
    check("t3_stall_stable", 64'(stable), 64'd1);
    res_ready = 1'b1;
    wait_done(200, "t3_done");
    check("t3_fc", 64'(fail_count), 64'd1);
    check("t3_q", 64'(exp_q.size()), 64'd0);

    // continuous scan, abort in a later dwell
    channel_mask = 32'h3;
    dwell_cycles = 32'd20;
    fail_mask = 32'h1;
    continuous = 1'b1;
    expect_res(5'd0);
    expect_res(5'd1);
    expect_res(5'd0);
    pulse_start();
    continuous = 1'b0;
    xf = 0;
    n = 0;
    while (xf < 3 && n < 500) begin
      if (res_valid && res_ready) xf++;
      tick();
      n++;
    end
    n = 0;
    while (chk_hold && n < 50) begin
      tick();
      n++;
    end
    check("t4_in_dwell", 64'(chk_hold), 64'd0);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_hold", 64'(chk_hold), 64'd1);
    check("t4_valid", 64'(res_valid), 64'd0);
    check("t4_done", 64'(done), 64'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) n++;
      tick();
    end
    check("t4_no_done", 64'(n), 64'd0);
    check("t4_fc_kept", 64'(fail_count), 64'd1);
    check("t4_q", 64'(exp_q.size()), 64'd0);

    // async reset in drain
    channel_mask = 32'h10;
    dwell_cycles = 32'd10;
    fail_mask = 32'h10;
    pulse_start();
    repeat (17) tick();
    check("t5_pre_hold", 64'(chk_hold), 64'd0);
    check("t5_pre_ch", 64'(chk_channel), 64'd4);
    #3;
    rst = 1'b1;
    #1;
    check("t5_hold", 64'(chk_hold), 64'd1);
    check("t5_ch", 64'(chk_channel), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_valid", 64'(res_valid), 64'd0);
    check("t5_rfail", res_failed, 64'd0);
    check("t5_fc", 64'(fail_count), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    expect_res(5'd4);
    pulse_start();
    wait_done(200, "t5_rerun_done");
    check("t5_rerun_fc", 64'(fail_count), 64'd1);
    check("t5_q", 64'(exp_q.size()), 64'd0);

    // zero dwell; stray start while busy
    channel_mask = 32'h6;
    dwell_cycles = 32'd0;
    fail_mask = 32'h2;
    expect_res(5'd1);
    expect_res(5'd2);
    pulse_start();
    n = 0;
    while (!res_valid && n < 100) begin
      if (n == 5) begin
        start = 1'b1;
        channel_mask = 32'hFF;
        continuous = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    continuous = 1'b0;
    check("t6_latency", 64'(n), 64'd14);
    wait_done(200, "t6_done");
    check("t6_fc", 64'(fail_count), 64'd1);
    check("t6_q", 64'(exp_q.size()), 64'd0);
    repeat (5) tick();
    check("t6_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
